cond_unit: RTL and testbench

Parametrised execute-stage condition unit, successor to the single-context combinational condition checker. It keeps a banked NZCV flag register per hardware context. It evaluates each instruction's 4-bit condition against the selected bank, with separate write enables for the NZ and CV flag groups. It also sequences IT-style predicated blocks of up to IT_DEPTH instructions. It sits between decode and the ALU writeback-enable logic; `cond_ex` gates register, memory and flag writes of the instruction in execute.

---
 rtl/cond_unit_if.sv | 37 +++
 rtl/cond_unit.sv | 169 ++++++++++++++++
 tb/tb_cond_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cond_unit_if.sv
// Bus between decode/ALU and the execute-stage condition unit.
// The master drives the instruction in execute; the slave (cond_unit)
// answers with the execute decision, the undef flag and its flag/IT view.
interface cond_unit_if #(
  parameter int NUM_CTX  = 1,
  parameter int IT_DEPTH = 4
);
  localparam int CW = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam int LW = $clog2(IT_DEPTH + 1);

  logic                valid;
  logic                stall;
  logic [CW-1:0]       ctx_sel;
  logic [3:0]          cond;
  logic [3:0]          alu_flags;
  logic [1:0]          flag_write;
  logic                it_start;
  logic [3:0]          it_cond;
  logic [IT_DEPTH-1:0] it_mask;
  logic [LW-1:0]       it_len;
  logic                cond_ex;
  logic                undef;
  logic [3:0]          flags_out;
  logic                it_active;

  modport master (
    output valid, stall, ctx_sel, cond, alu_flags, flag_write,
           it_start, it_cond, it_mask, it_len,
    input  cond_ex, undef, flags_out, it_active
  );

  modport slave (
    input  valid, stall, ctx_sel, cond, alu_flags, flag_write,
           it_start, it_cond, it_mask, it_len,
    output cond_ex, undef, flags_out, it_active
  );
endinterface

// File: rtl/cond_unit.sv
// Execute-stage condition unit: banked NZCV flags per hardware context,
// condition evaluation against the selected bank, split NZ/CV flag writes
// and sequencing of IT-style predicated blocks of up to IT_DEPTH slots.
module cond_unit #(
  parameter int NUM_CTX  = 1,
  parameter int IT_DEPTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  cond_unit_if.slave bus
);
  localparam int CW = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam int LW = $clog2(IT_DEPTH + 1);
  // Bank count rounded up to the ctx_sel range so any select value indexes
  // a real entry; entries at or above NUM_CTX are never written.
  localparam int NB = 1 << CW;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE, CS, CC, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} it_state_e;

  it_state_e           state_q, state_d;
  logic [LW-1:0]       count_q, count_d;
  logic [IT_DEPTH-1:0] mask_q, mask_d;
  logic [3:0]          it_cond_q, it_cond_d;
  logic [CW-1:0]       it_ctx_q, it_ctx_d;
  logic [NB-1:0][3:0]  bank_q;

  logic       ctx_ok;
  logic       accept;
  logic       in_it;
  logic       len_ok;
  logic       it_legal;
  logic       flag_we;
  logic       cond_ex_c;
  logic       undef_c;
  logic [3:0] flags_cur;
  logic [3:0] eff_cond;

  // Standard 16-entry condition table over {N,Z,C,V}; NV never executes.
  function automatic logic eval_cond(input cond_e c, input logic [3:0] f);
    logic n, z, cf, v, ge, gt, hi, res;
    {n, z, cf, v} = f;
    ge = (n == v);
    gt = ~z & ge;
    hi = cf & ~z;
    unique case (c)
      EQ: res = z;
      NE: res = ~z;
      CS: res = cf;
      CC: res = ~cf;
      MI: res = n;
      PL: res = ~n;
      VS: res = v;
      VC: res = ~v;
      HI: res = hi;
      LS: res = ~hi;
      GE: res = ge;
      LT: res = ~ge;
      GT: res = gt;
      LE: res = ~gt;
      AL: res = 1'b1;
      NV: res = 1'b0;
    endcase
    return res;
  endfunction

  assign ctx_ok    = (int'(bus.ctx_sel) < NUM_CTX);
  assign accept    = bus.valid & ~bus.stall;
  assign flags_cur = ctx_ok ? bank_q[bus.ctx_sel] : 4'b0000;

  // Predication applies only to the context that opened the block.
  assign in_it    = (state_q == ACTIVE) && (bus.ctx_sel == it_ctx_q);
  assign eff_cond = in_it ? (mask_q[0] ? it_cond_q : (it_cond_q ^ 4'b0001))
                          : bus.cond;

  // Only one IT block can be tracked, so any it_start while ACTIVE is nesting.
  assign len_ok   = (bus.it_len != '0) && (int'(bus.it_len) <= IT_DEPTH);
  assign it_legal = (state_q == IDLE) && len_ok && (bus.it_cond != 4'hF);

  // Execute decision and undef for the instruction currently in execute.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cond_ex_c = 1'b0;
    undef_c   = 1'b0;
    if (bus.valid) begin
      if (bus.it_start) begin
        cond_ex_c = it_legal;
        undef_c   = ~it_legal;
      end else if (eff_cond == 4'hF) begin
        // NV outside IT, or the else-slot of an AL block.
        undef_c = 1'b1;
      end else begin
        cond_ex_c = eval_cond(cond_e'(eff_cond), flags_cur);
      end
    end
  end

  assign bus.cond_ex   = cond_ex_c;
  assign bus.undef     = undef_c;
  assign bus.flags_out = flags_cur;
  assign bus.it_active = (count_q != '0);

  // The IT instruction itself never writes flags; cond_ex already excludes undef.
  assign flag_we = accept & ~bus.it_start & cond_ex_c & ctx_ok;

  // Flag banks: only the selected bank, and only the enabled groups, update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the flag bank is a small register array, not RAM, and must read
      // as zero straight out of reset, so every entry is cleared.
      bank_q <= '0;
    end else if (flag_we) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (bus.flag_write[1]) bank_q[bus.ctx_sel][3:2] <= bus.alu_flags[3:2];
      if (bus.flag_write[0]) bank_q[bus.ctx_sel][1:0] <= bus.alu_flags[1:0];
    end
  end

  // IT sequencer next state: open a block on a legal IT, consume one slot per
  // accepted instruction of the owning context, close when the count hits 0.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mask_d    = mask_q;
    it_cond_d = it_cond_q;
    it_ctx_d  = it_ctx_q;
    unique case (state_q)
      IDLE: begin
        if (accept && bus.it_start && it_legal) begin
          state_d   = ACTIVE;
          count_d   = bus.it_len;
          mask_d    = bus.it_mask;
          it_cond_d = bus.it_cond;
          it_ctx_d  = bus.ctx_sel;
        end
      end
      ACTIVE: begin
        if (accept && !bus.it_start && in_it) begin
          mask_d  = mask_q >> 1;
          count_d = count_q - LW'(1);
          if (count_q == LW'(1)) state_d = IDLE;
        end
      end
    endcase
  end

  // IT sequencer state register; reset abandons any open block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mask_q    <= '0;
      it_cond_q <= 4'h0;
      it_ctx_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mask_q    <= mask_d;
      it_cond_q <= it_cond_d;
      it_ctx_q  <= it_ctx_d;
    end
  end
endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: the driver computes each cycle's expected
// response from a behavioural model (flag array plus a queue of pending IT
// slot conditions) and queues it; the monitor pops and compares at negedge.
module tb_cond_unit;
  localparam int NUM_CTX  = 2;
  localparam int IT_DEPTH = 4;
  localparam int CW       = 1;
  localparam int LW       = 3;

  logic clk;
  logic rst_n;

  cond_unit_if #(.NUM_CTX(NUM_CTX), .IT_DEPTH(IT_DEPTH)) bus ();

  cond_unit #(.NUM_CTX(NUM_CTX), .IT_DEPTH(IT_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] cond_ex;
    logic [3:0] undef;
    logic [3:0] flags;
    logic [3:0] active;
  } exp_t;

  exp_t     exp_q[$];
  int       errors = 0;
  int       checks = 0;

  // Reference model state.
  bit [3:0] flags_m [NUM_CTX];
  bit [3:0] slots[$];
  bit [CW-1:0] it_ctx_m;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Condition truth from the architectural pairing: even codes test a base
  // predicate, odd codes its inverse (except AL).
  function automatic bit cond_holds(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cf, v, r;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && c[3:1] != 3'd7) r = !r;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CTX; i++) flags_m[i] = 4'b0000;
    slots.delete();
    it_ctx_m = '0;
  endtask

  // Drive one cycle, queue its expected response, advance the model at the edge.
  task automatic step(input string tag, input bit v, input bit st, input bit [CW-1:0] ctx,
                      input bit [3:0] c, input bit [3:0] af, input bit [1:0] fw,
                      input bit its, input bit [3:0] itc, input bit [IT_DEPTH-1:0] msk,
                      input bit [LW-1:0] len);
    exp_t e;
    bit in_it, legal, ex, ud;
    bit [3:0] ec;
    bus.valid = v; bus.stall = st; bus.ctx_sel = ctx; bus.cond = c;
    bus.alu_flags = af; bus.flag_write = fw; bus.it_start = its;
    bus.it_cond = itc; bus.it_mask = msk; bus.it_len = len;
    in_it = (slots.size() != 0) && (ctx == it_ctx_m);
    ec    = in_it ? slots[0] : c;
    legal = (slots.size() == 0) && (len >= 1) && (int'(len) <= IT_DEPTH) && (itc != 4'hF);
    ex = 1'b0; ud = 1'b0;
    if (v) begin
      if (its) begin
        ex = legal; ud = !legal;
      end else if (ec == 4'hF) begin
        ud = 1'b1;
      end else begin
        ex = cond_holds(ec, flags_m[ctx]);
      end
    end
    e.tag = tag;
    e.cond_ex = {3'b000, ex};
    e.undef   = {3'b000, ud};
    e.flags   = flags_m[ctx];
    e.active  = {3'b000, slots.size() != 0};
    exp_q.push_back(e);
    @(posedge clk);
    if (rst_n && v && !st) begin
      if (its) begin
        if (legal) begin
          it_ctx_m = ctx;
          for (int i = 0; i < int'(len); i++) slots.push_back(msk[i] ? itc : (itc ^ 4'b0001));
        end
      end else begin
        if (ex && fw[1]) flags_m[ctx][3:2] = af[3:2];
        if (ex && fw[0]) flags_m[ctx][1:0] = af[1:0];
        if (in_it) void'(slots.pop_front());
      end
    end
    #1;
  endtask

  task automatic ins(input string tag, input bit [CW-1:0] ctx, input bit [3:0] c,
                     input bit [3:0] af, input bit [1:0] fw);
    step(tag, 1'b1, 1'b0, ctx, c, af, fw, 1'b0, 4'h0, 4'h0, 3'd0);
  endtask

  task automatic it_ins(input string tag, input bit [CW-1:0] ctx, input bit [3:0] itc,
                        input bit [IT_DEPTH-1:0] msk, input bit [LW-1:0] len);
    step(tag, 1'b1, 1'b0, ctx, 4'h0, 4'h0, 2'b00, 1'b1, itc, msk, len);
  endtask

  task automatic idle(input string tag, input bit [CW-1:0] ctx);
    step(tag, 1'b0, 1'b0, ctx, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 3'd0);
  endtask

  task automatic do_reset();
    bus.valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    idle("reset0", 1'b0);
    idle("reset1", 1'b1);
    rst_n = 1'b1;
  endtask

  // Monitor: compare every queued expectation against the DUT at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".cond_ex"},   {3'b000, bus.cond_ex},   e.cond_ex);
        check({e.tag, ".undef"},     {3'b000, bus.undef},     e.undef);
        check({e.tag, ".flags_out"}, bus.flags_out,           e.flags);
        check({e.tag, ".it_active"}, {3'b000, bus.it_active}, e.active);
      end
    end
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    bus.valid = 1'b0; bus.stall = 1'b0; bus.ctx_sel = '0; bus.cond = 4'h0;
    bus.alu_flags = 4'h0; bus.flag_write = 2'b00; bus.it_start = 1'b0;
    bus.it_cond = 4'h0; bus.it_mask = '0; bus.it_len = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Basic evaluation from reset flags.
    ins("eq_z0", 1'b0, 4'h0, 4'h0, 2'b00);
    ins("ne_z0", 1'b0, 4'h1, 4'h0, 2'b00);
    ins("nv",    1'b0, 4'hF, 4'hF, 2'b11);

    // Split NZ / CV writes; a failing instruction must not write.
    ins("wr_nz",   1'b0, 4'hE, 4'hF, 2'b10);
    ins("wr_cv",   1'b0, 4'hE, 4'h3, 2'b01);
    ins("no_wr",   1'b0, 4'h1, 4'h0, 2'b11);
    idle("flags_hold", 1'b0);

    // Bank isolation.
    ins("ctx1_eq", 1'b1, 4'h0, 4'h0, 2'b00);
    ins("ctx0_eq", 1'b0, 4'h0, 4'h0, 2'b00);

    // IT EQ, mask 0101, len 4 with Z=1; cond fields ignored.
    it_ins("it_open", 1'b0, 4'h0, 4'b0101, 3'd4);
    ins("it_s0", 1'b0, 4'h1, 4'h0, 2'b00);
    ins("it_s1", 1'b0, 4'h0, 4'h0, 2'b00);
    ins("it_s2", 1'b0, 4'hF, 4'h0, 2'b00);
    ins("it_s3", 1'b0, 4'hE, 4'h0, 2'b00);
    idle("it_done", 1'b0);

    // Stall and foreign context during an IT block, then illegal forms.
    it_ins("it2_open", 1'b0, 4'h0, 4'b1111, 3'd4);
    ins("it2_s0", 1'b0, 4'h1, 4'h0, 2'b00);
    for (int i = 0; i < 3; i++)
      step("it2_stall", 1'b1, 1'b1, 1'b0, 4'h1, 4'h0, 2'b11, 1'b0, 4'h0, 4'h0, 3'd0);
    ins("it2_ctx1", 1'b1, 4'h1, 4'h0, 2'b00);
    it_ins("it2_nest", 1'b0, 4'h1, 4'b1111, 3'd2);
    it_ins("it2_nest_c1", 1'b1, 4'h1, 4'b1111, 3'd2);
    ins("it2_s1", 1'b0, 4'h1, 4'h0, 2'b00);
    ins("it2_s2", 1'b0, 4'h1, 4'h0, 2'b00);
    ins("it2_s3", 1'b0, 4'h1, 4'h0, 2'b00);
    it_ins("it_len0",  1'b0, 4'h0, 4'b1111, 3'd0);
    it_ins("it_len5",  1'b0, 4'h0, 4'b1111, 3'd5);
    it_ins("it_nv",    1'b0, 4'hF, 4'b1111, 3'd2);
    idle("it_idle", 1'b0);

    // AL block with an else slot: that slot is undefined.
    it_ins("al_open", 1'b0, 4'hE, 4'b0001, 3'd2);
    ins("al_then", 1'b0, 4'h0, 4'h0, 2'b00);
    ins("al_else", 1'b0, 4'h0, 4'h0, 2'b00);

    // A flag write in one slot is seen by the next slot.
    it_ins("fw_open", 1'b0, 4'h0, 4'b1111, 3'd3);
    ins("fw_s0", 1'b0, 4'h0, 4'h0, 2'b10);
    ins("fw_s1", 1'b0, 4'h0, 4'h0, 2'b00);
    ins("fw_s2", 1'b0, 4'h0, 4'h0, 2'b00);

    // Reset in the middle of an AL block: next instruction is unpredicated.
    it_ins("rst_open", 1'b0, 4'hE, 4'b1111, 3'd4);
    ins("rst_s0", 1'b0, 4'h0, 4'h0, 2'b00);
    do_reset();
    ins("post_rst_eq", 1'b0, 4'h0, 4'h0, 2'b00);
    ins("post_rst_ne", 1'b0, 4'h1, 4'h0, 2'b00);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      bit v, st, its;
      bit [CW-1:0] ctx;
      bit [LW-1:0] len;
      bit [3:0] itc;
      v   = ($urandom_range(0, 7) != 0);
      st  = ($urandom_range(0, 4) == 0);
      its = ($urandom_range(0, 7) == 0);
      ctx = CW'($urandom_range(0, NUM_CTX - 1));
      len = ($urandom_range(0, 5) == 0) ? LW'($urandom_range(0, 7)) : LW'($urandom_range(1, 4));
      itc = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      step("rand", v, st, ctx, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), its, itc, 4'($urandom_range(0, 15)), len);
    end

    idle("drain", 1'b0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
